readout_drain: RTL and testbench

Host-side reader for the core's accumulated-output readout path. On a host start it issues the single-cycle readout_start pulse to the core and captures the len_onij output rows the core streams back on readout, one row per cycle with no stall. The rows are buffered in a local FIFO and presented to the host over a valid/ready stream. It replaces the bench-driven readout/compare sequence in hardware.

---
 rtl/readout_pkg.sv | 19 +
 rtl/drain_fifo.sv | 54 +++++
 rtl/readout_drain.sv | 142 ++++++++++++++
 tb/tb_readout_drain.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and defaults for the readout drain path: FSM states, row width and the
// default readout geometry.
package readout_pkg;

  localparam int unsigned COL         = 8;
  localparam int unsigned PSUM_BW     = 16;
  localparam int unsigned ROW_W       = COL * PSUM_BW;
  localparam int unsigned LEN_ONIJ    = 16;
  localparam int unsigned CAP_LAT_DEF = 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StKick    = 3'd1,
    StWait    = 3'd2,
    StCapture = 3'd3,
    StDrain   = 3'd4
  } state_e;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous capture FIFO. A push into a full FIFO is accepted only when a pop happens in the
// same cycle; the pointers wrap naturally and the count is one bit wider than a pointer.
module drain_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       din,
  output logic [width-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en & ~rd_en) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (rd_en & ~wr_en) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

  // Storage is not reset; the top gates the head row with empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/readout_drain.sv
// Host-side readout reader: kicks the core, captures len_onij rows into a FIFO and streams them
// out over valid/ready. Define READOUT_RELU_EN to clamp negative lanes to zero before storage.
module readout_drain
  import readout_pkg::*;
#(
  parameter int unsigned col        = COL,
  parameter int unsigned psum_bw    = PSUM_BW,
  parameter int unsigned len_onij   = LEN_ONIJ,
  parameter int unsigned CAP_LAT    = CAP_LAT_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   readout_start,
  input  logic [col*psum_bw-1:0] readout,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned RowW    = col * psum_bw;
  localparam int unsigned RowCntW = (len_onij > 1) ? $clog2(len_onij) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RowCntW-1:0] LastRow = RowCntW'(len_onij - 1);
  localparam logic [2:0]         LatM1   = 3'(CAP_LAT - 1);

  state_e               state_q, state_d;
  logic [RowCntW-1:0]   row_q, row_d;
  logic [2:0]           wait_q, wait_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic                 push, pop, drop;
  logic                 fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic [RowW:0]        fifo_din, fifo_dout;
  logic [RowW-1:0]      row_in;

`ifdef READOUT_RELU_EN
  always_comb begin
    row_in = readout;
    for (int unsigned j = 0; j < col; j++) begin
      if (readout[psum_bw*j + psum_bw - 1]) row_in[psum_bw*j +: psum_bw] = '0;
    end
  end
`else
  assign row_in = readout;
`endif

  assign pop      = ~fifo_empty & out_ready;
  assign push     = (state_q == StCapture) & (~fifo_full | pop);
  // Dropped rows still advance the row counter so the capture window closes on time.
  assign drop     = (state_q == StCapture) & fifo_full & ~pop;
  assign fifo_din = {(row_q == LastRow), row_in};

  drain_fifo #(
    .width (RowW + 1),
    .depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    wait_d     = wait_q;
    overflow_d = overflow_q | drop;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StKick;
          overflow_d = 1'b0;
        end
      end
      StKick: begin
        row_d   = '0;
        wait_d  = 3'd1;
        state_d = (CAP_LAT == 1) ? StCapture : StWait;
      end
      StWait: begin
        if (wait_q == LatM1) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      StCapture: begin
        if (row_q == LastRow) begin
          row_d   = '0;
          state_d = StDrain;
        end else begin
          row_d = row_q + RowCntW'(1);
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Covers both endings: the last-flagged pop, or the final pop after the last row was dropped.
  assign done_d = (state_q == StDrain) & pop & (fifo_count == CntW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      row_q      <= '0;
      wait_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign readout_start = (state_q == StKick);
  assign busy          = (state_q != StIdle);
  assign out_valid     = ~fifo_empty;
  assign out_data      = fifo_empty ? '0 : fifo_dout[RowW-1:0];
  assign out_last      = ~fifo_empty & fifo_dout[RowW];
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_readout_drain.sv
// Bench for readout_drain: two instances (CAP_LAT=1/depth 16 and CAP_LAT=3/depth 4) share a
// core model; a queue-based reference predicts every output cycle by cycle.
module tb_readout_drain;

  localparam int LEN = 16;

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } ent_t;

  typedef struct {
    int sel;       // 0: lat 1 / depth 16, 1: lat 3 / depth 4
    int mode;      // ready: 0 always, 1 pattern 1001, 2 low while capturing, 3 random
    int data;      // rows: 0 ramp, 1 random, 2 alternating FFF0/0010 lanes
    bit hold;      // keep start high until done
    int exp_out;   // expected transfers (-1: model only)
    int exp_last;  // expected out_last transfers (-1: model only)
    int exp_ovf;   // expected final overflow (-1: model only)
  } scn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, out_ready = 1'b0;
  logic [127:0] rd_bus = '0;
  logic a_rs, a_valid, a_last, a_busy, a_done, a_ovf;
  logic b_rs, b_valid, b_last, b_busy, b_done, b_ovf;
  logic [127:0] a_data, b_data;

  readout_drain #(.CAP_LAT(1), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .readout_start(a_rs), .readout(rd_bus),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .out_last(a_last),
    .busy(a_busy), .done(a_done), .overflow(a_ovf)
  );

  readout_drain #(.CAP_LAT(3), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .readout_start(b_rs), .readout(rd_bus),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .out_last(b_last),
    .busy(b_busy), .done(b_done), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic sel = 1'b0;

  // Reference model state
  ent_t m_q[$];
  int   m_t = -1;          // cycles since the accepted start, -1 when idle
  bit   m_drain = 1'b0;
  bit   m_done = 1'b0;
  bit   m_ovf[2] = '{1'b0, 1'b0};
  int   m_lat = 1, m_depth = 16, n_push = 0;
  logic [127:0] rows[LEN];

  int got, lasts, kicks;
  bit have_first;
  logic [127:0] first_out;

  function automatic logic [5:0] cur_stat();
    return sel ? {b_rs, b_valid, b_last, b_busy, b_done, b_ovf}
               : {a_rs, a_valid, a_last, a_busy, a_done, a_ovf};
  endfunction

  function automatic logic [127:0] cur_data();
    return sel ? b_data : a_data;
  endfunction

  function automatic logic [127:0] ref_row(input logic [127:0] r);
    logic [127:0] o;
    o = r;
`ifdef READOUT_RELU_EN
    for (int j = 0; j < 8; j++) if ($signed(r[16*j +: 16]) < 0) o[16*j +: 16] = 16'h0000;
`endif
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: compare outputs at the falling edge, drive inputs, advance the model.
  task automatic step(input logic st, input logic rdy);
    int   ri, sz0;
    bit   push, pop, dn, hd_last;
    ent_t e;
    logic [5:0] e_stat;
    @(negedge clk);
    sz0 = m_q.size();
    hd_last = (sz0 > 0) ? m_q[0].last : 1'b0;
    e_stat = {m_t == 0, sz0 > 0, hd_last, m_t >= 0, m_done, m_ovf[sel]};
    chk("status{rs,valid,last,busy,done,ovf}", 128'(cur_stat()), 128'(e_stat));
    chk("out_data", cur_data(), (sz0 > 0) ? m_q[0].d : 128'(0));
    if (cur_stat()[4] && rdy) begin
      got++;
      lasts += int'(cur_stat()[3]);
      if (!have_first) begin
        first_out  = cur_data();
        have_first = 1'b1;
      end
    end
    kicks += int'(cur_stat()[5]);

    start_a = st & ~sel;
    start_b = st & sel;
    out_ready = rdy;
    ri = m_t - m_lat;
    push = (m_t >= 0) && !m_drain && ri >= 0 && ri < LEN;
    rd_bus = push ? rows[ri] : {$urandom(), $urandom(), $urandom(), $urandom()};

    pop = (sz0 > 0) && rdy;
    dn = 1'b0;
    if (pop) begin
      void'(m_q.pop_front());
      if (m_drain && m_q.size() == 0) dn = 1'b1;
    end
    if (push) begin
      n_push++;
      if (sz0 == m_depth && !pop) begin
        m_ovf[sel] = 1'b1;
      end else begin
        e.d = ref_row(rows[ri]);
        e.last = (ri == LEN - 1);
        m_q.push_back(e);
      end
    end
    if (m_t < 0) begin
      if (st) begin
        m_t = 0;
        m_ovf[sel] = 1'b0;
      end
    end else if (m_drain) begin
      if (sz0 == 0) begin
        m_t = -1;
        m_drain = 1'b0;
      end
    end else begin
      if (push && ri == LEN - 1) m_drain = 1'b1;
      m_t++;
    end
    m_done = dn;
  endtask

  task automatic load(input int s, input int data);
    sel = s[0];
    m_lat = s[0] ? 3 : 1;
    m_depth = s[0] ? 4 : 16;
    for (int i = 0; i < LEN; i++) begin
      for (int j = 0; j < 8; j++) begin
        case (data)
          0: rows[i][16*j +: 16] = 16'(i * 8 + j);
          1: rows[i][16*j +: 16] = 16'($urandom());
          default: rows[i][16*j +: 16] = j[0] ? 16'h0010 : 16'hFFF0;
        endcase
      end
    end
  endtask

  task automatic run_scn(input scn_t s, input string nm);
    int cyc;
    bit seen_done;
    logic st, rdy;
    load(s.sel, s.data);
    got = 0; lasts = 0; kicks = 0; have_first = 1'b0; seen_done = 1'b0;
    cyc = 0;
    while (!(seen_done && m_t < 0) && cyc < 400) begin
      if (m_done) seen_done = 1'b1;
      st = (cyc == 0) || (s.hold && !seen_done);
      case (s.mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: rdy = !(m_t >= 0 && !m_drain);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      step(st, rdy);
      cyc++;
    end
    if (cyc >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: done not seen within 400 cycles", nm);
    end
    if (s.exp_out >= 0) chk({nm, " transfers"}, 128'(got), 128'(s.exp_out));
    if (s.exp_last >= 0) chk({nm, " last_count"}, 128'(lasts), 128'(s.exp_last));
    chk({nm, " kick_pulses"}, 128'(kicks), 128'(1));
    if (s.exp_ovf >= 0) chk({nm, " overflow_end"}, 128'(cur_stat()[0]), 128'(s.exp_ovf));
  endtask

  scn_t tbl[9];
  scn_t rs;

  initial begin
    tbl[0] = '{0, 0, 0, 1'b0, 16, 1, 0};    // basic drain
    tbl[1] = '{0, 1, 1, 1'b0, 16, 1, 0};    // backpressure 1,0,0,1
    tbl[2] = '{1, 2, 1, 1'b0, 4, 0, 1};     // overflow, depth 4
    tbl[3] = '{1, 0, 0, 1'b1, 16, 1, 0};    // start held, lat 3, clears overflow
    tbl[4] = '{0, 0, 2, 1'b0, 16, 1, 0};    // lane sign handling
    tbl[5] = '{0, 3, 1, 1'b0, 16, 1, 0};    // random ready, cannot overflow
    tbl[6] = '{1, 3, 1, 1'b0, -1, -1, -1};
    tbl[7] = '{1, 1, 1, 1'b0, -1, -1, -1};
    tbl[8] = '{1, 0, 1, 1'b0, 16, 1, 0};

    #2;
    chk("reset_status", 128'({a_rs, a_valid, a_last, a_busy, a_done, a_ovf,
                              b_rs, b_valid, b_last, b_busy, b_done, b_ovf}), '0);
    chk("reset_data", a_data | b_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_scn(tbl[i], $sformatf("scn%0d", i));
      if (i == 4) begin
`ifdef READOUT_RELU_EN
        chk("lane0_fff0", 128'(first_out[15:0]), 128'(16'h0000));
`else
        chk("lane0_fff0", 128'(first_out[15:0]), 128'(16'hFFF0));
`endif
        chk("lane1_0010", 128'(first_out[31:16]), 128'(16'h0010));
      end
    end

    // Reset in the middle of a capture, after five pushes.
    load(0, 0);
    n_push = 0;
    step(1'b1, 1'b1);
    for (int k = 0; k < 40 && n_push < 5; k++) step(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_status", 128'({a_rs, a_valid, a_last, a_busy, a_done, a_ovf,
                                 b_rs, b_valid, b_last, b_busy, b_done, b_ovf}), '0);
    chk("midreset_data", a_data | b_data, '0);
    m_q.delete();
    m_t = -1;
    m_drain = 1'b0;
    m_done = 1'b0;
    m_ovf = '{1'b0, 1'b0};
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_scn(tbl[0], "after_reset");

    for (int r = 0; r < 6; r++) begin
      rs = '{r % 2, 3, 1, 1'b0, -1, -1, -1};
      run_scn(rs, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
